// File: rtl/banked_memory_pkg.sv
// rtl/banked_memory_pkg.sv - shared defaults, write-mode constants and bank-select sizing for banked_memory
package banked_memory_pkg;

   localparam int DEFAULT_RAM_WIDTH  = 8;
   localparam int DEFAULT_NB_ADDRESS = 10;
   localparam int DEFAULT_DEPTH      = 1024;
   localparam int DEFAULT_N_BANKS    = 3;

   // i_wrMode encodings
   localparam logic MODE_EXPLICIT = 1'b0;
   localparam logic MODE_STREAM   = 1'b1;

   // Bank select width; a single bank still needs one select bit
   function automatic int bank_bits(input int n_banks);
      return (n_banks <= 1) ? 1 : $clog2(n_banks);
   endfunction

endpackage

// File: rtl/banked_memory_if.sv
// rtl/banked_memory_if.sv - write/read bus of banked_memory with master/slave views
interface banked_memory_if import banked_memory_pkg::*; #(
   parameter int RAM_WIDTH  = DEFAULT_RAM_WIDTH,
   parameter int NB_ADDRESS = DEFAULT_NB_ADDRESS,
   parameter int N_BANKS    = DEFAULT_N_BANKS,
   parameter int NB_BANK    = bank_bits(N_BANKS)
) ();

   logic [RAM_WIDTH-1:0]         i_data;
   logic                         i_wrEnable;
   logic                         i_wrMode;
   logic [NB_ADDRESS-1:0]        i_writeAdd;
   logic [NB_BANK-1:0]           i_wrBank;
   logic                         i_ptrClear;
   logic                         i_rdEnable;
   logic [NB_ADDRESS-1:0]        i_readAdd;
   logic [N_BANKS*RAM_WIDTH-1:0] o_data;
   logic                         o_valid;
   logic [NB_BANK-1:0]           o_wrBank;
   logic                         o_lineDone;

   modport master (
      output i_data, i_wrEnable, i_wrMode, i_writeAdd, i_wrBank, i_ptrClear,
             i_rdEnable, i_readAdd,
      input  o_data, o_valid, o_wrBank, o_lineDone
   );

   modport slave (
      input  i_data, i_wrEnable, i_wrMode, i_writeAdd, i_wrBank, i_ptrClear,
             i_rdEnable, i_readAdd,
      output o_data, o_valid, o_wrBank, o_lineDone
   );

endinterface

// File: rtl/bram_bank.sv
// rtl/bram_bank.sv - one simple dual-port read-first RAM bank with registered read
module bram_bank import banked_memory_pkg::*; #(
   parameter int RAM_WIDTH  = DEFAULT_RAM_WIDTH,
   parameter int NB_ADDRESS = DEFAULT_NB_ADDRESS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [NB_ADDRESS-1:0] wr_addr,
   input  logic [RAM_WIDTH-1:0]  wr_data,
   input  logic                  rd_en,
   input  logic [NB_ADDRESS-1:0] rd_addr,
   output logic [RAM_WIDTH-1:0]  rd_data
);

   // Full address space so any read address indexes real storage; the top
   // keeps writes inside the used line length.
   localparam int MEM_WORDS = 1 << NB_ADDRESS;

   logic [RAM_WIDTH-1:0] mem [MEM_WORDS];
   logic [RAM_WIDTH-1:0] rd_data_d, rd_data_q;

   // Write port; storage itself is never reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read-first: the array is sampled before this edge's write lands; hold when idle
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem[rd_addr];
      end
   end

   // Registered read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/banked_memory.sv
// rtl/banked_memory.sv - N-bank column-read line buffer; define BANKED_MEMORY_OUTREG_EN for a 2-cycle registered read
module banked_memory import banked_memory_pkg::*; #(
   parameter int RAM_WIDTH  = DEFAULT_RAM_WIDTH,
   parameter int NB_ADDRESS = DEFAULT_NB_ADDRESS,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int N_BANKS    = DEFAULT_N_BANKS,
   parameter int NB_BANK    = bank_bits(N_BANKS)
) (
   input  logic          i_CLK,
   input  logic          i_reset,
   banked_memory_if.slave bus
);

   logic [NB_ADDRESS-1:0]        wr_ptr_d, wr_ptr_q;
   logic [NB_BANK-1:0]           bank_ptr_d, bank_ptr_q;
   logic                         line_done_d, line_done_q;
   logic                         rd_valid_d, rd_valid_q;
   logic                         stream_wr;
   logic                         explicit_wr;
   logic [NB_ADDRESS-1:0]        wr_addr;
   logic [NB_BANK-1:0]           wr_bank;
   logic [N_BANKS-1:0]           bank_we;
   logic [N_BANKS*RAM_WIDTH-1:0] ram_data;

   // Write decode: stream writes use the pointers, explicit writes are range-checked
   always_comb begin
      stream_wr   = bus.i_wrEnable && (bus.i_wrMode == MODE_STREAM);
      explicit_wr = bus.i_wrEnable && (bus.i_wrMode == MODE_EXPLICIT)
                    && (32'(bus.i_wrBank) < N_BANKS)
                    && (32'(bus.i_writeAdd) < DEPTH);
      wr_addr     = stream_wr ? wr_ptr_q   : bus.i_writeAdd;
      wr_bank     = stream_wr ? bank_ptr_q : bus.i_wrBank;
      bank_we     = '0;
      for (int k = 0; k < N_BANKS; k++) begin
         bank_we[k] = (stream_wr || explicit_wr) && (32'(wr_bank) == k);
      end
   end

   // Stream pointers: clear wins over increment; end of line rotates the bank
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      bank_ptr_d  = bank_ptr_q;
      line_done_d = 1'b0;
      rd_valid_d  = bus.i_rdEnable;
      if (bus.i_ptrClear) begin
         wr_ptr_d   = '0;
         bank_ptr_d = '0;
      end else if (stream_wr) begin
         if (32'(wr_ptr_q) == DEPTH - 1) begin
            wr_ptr_d    = '0;
            bank_ptr_d  = (32'(bank_ptr_q) == N_BANKS - 1) ? '0 : bank_ptr_q + 1'b1;
            line_done_d = 1'b1;
         end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
      end
   end

   // Pointer, line-done pulse and read-valid registers
   always_ff @(posedge i_CLK or negedge i_reset) begin
      if (!i_reset) begin
         wr_ptr_q    <= '0;
         bank_ptr_q  <= '0;
         line_done_q <= 1'b0;
         rd_valid_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         bank_ptr_q  <= bank_ptr_d;
         line_done_q <= line_done_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   for (genvar k = 0; k < N_BANKS; k++) begin : g_bank
      bram_bank #(
         .RAM_WIDTH  (RAM_WIDTH),
         .NB_ADDRESS (NB_ADDRESS)
      ) u_bank (
         .clk     (i_CLK),
         .rst_n   (i_reset),
         .wr_en   (bank_we[k]),
         .wr_addr (wr_addr),
         .wr_data (bus.i_data),
         .rd_en   (bus.i_rdEnable),
         .rd_addr (bus.i_readAdd),
         .rd_data (ram_data[k*RAM_WIDTH +: RAM_WIDTH])
      );
   end

`ifdef BANKED_MEMORY_OUTREG_EN
   logic [N_BANKS*RAM_WIDTH-1:0] out_data_d, out_data_q;
   logic                         out_valid_d, out_valid_q;

   // Second stage loads only a fresh RAM result so o_data holds between reads
   always_comb begin
      out_valid_d = rd_valid_q;
      out_data_d  = out_data_q;
      if (rd_valid_q) begin
         out_data_d = ram_data;
      end
   end

   // Output register stage
   always_ff @(posedge i_CLK or negedge i_reset) begin
      if (!i_reset) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.o_data  = out_data_q;
   assign bus.o_valid = out_valid_q;
`else
   assign bus.o_data  = ram_data;
   assign bus.o_valid = rd_valid_q;
`endif

   assign bus.o_wrBank   = bank_ptr_q;
   assign bus.o_lineDone = line_done_q;

endmodule

// File: tb/tb_banked_memory.sv
// tb/tb_banked_memory.sv - self-checking bench for banked_memory (honours BANKED_MEMORY_OUTREG_EN)
module tb_banked_memory;
   import banked_memory_pkg::*;

   localparam int RW    = 8;
   localparam int NA    = 3;
   localparam int DEPTH = 4;
   localparam int NB    = 3;
   localparam int NBB   = 2;
`ifdef BANKED_MEMORY_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   banked_memory_if #(.RAM_WIDTH(RW), .NB_ADDRESS(NA), .N_BANKS(NB), .NB_BANK(NBB)) bus ();

   banked_memory #(
      .RAM_WIDTH(RW), .NB_ADDRESS(NA), .DEPTH(DEPTH), .N_BANKS(NB), .NB_BANK(NBB)
   ) dut (
      .i_CLK   (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Reference model: plain word array per bank plus line-buffer cursor
   logic [7:0]  m [NB][DEPTH];
   int          mp, mb;
   logic        exp_valid, exp_ld;
   logic [23:0] exp_data;
   logic        pv;
   logic [23:0] pd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".valid"},    32'(bus.o_valid),    32'(exp_valid));
      check({tag, ".data"},     32'(bus.o_data),     32'(exp_data));
      check({tag, ".bank"},     32'(bus.o_wrBank),   32'(mb));
      check({tag, ".linedone"}, 32'(bus.o_lineDone), 32'(exp_ld));
   endtask

   task automatic model_reset();
      mp = 0; mb = 0;
      exp_valid = 1'b0; exp_ld = 1'b0; exp_data = '0;
      pv = 1'b0; pd = '0;
   endtask

   task automatic drive_idle();
      bus.i_data = '0; bus.i_wrEnable = 1'b0; bus.i_wrMode = 1'b0;
      bus.i_writeAdd = '0; bus.i_wrBank = '0; bus.i_ptrClear = 1'b0;
      bus.i_rdEnable = 1'b0; bus.i_readAdd = '0;
   endtask

   // One clock of stimulus, model update at the edge, then full output check
   task automatic step(input logic we, input logic md, input int wa, input int wb,
                       input logic [7:0] d, input logic clr, input logic re, input int ra);
      logic [23:0] row;
      @(negedge clk);
      bus.i_wrEnable = we;  bus.i_wrMode  = md;  bus.i_writeAdd = 3'(wa);
      bus.i_wrBank   = 2'(wb); bus.i_data = d;   bus.i_ptrClear = clr;
      bus.i_rdEnable = re;  bus.i_readAdd = 3'(ra);
      @(posedge clk);
      row = '0;
      for (int k = 0; k < NB; k++) row[k*8 +: 8] = m[k][ra];
      exp_ld = 1'b0;
      if (we && md == MODE_STREAM) begin
         m[mb][mp] = d;
         if (!clr) begin
            mp = (mp + 1) % DEPTH;
            if (mp == 0) begin
               mb     = (mb + 1) % NB;
               exp_ld = 1'b1;
            end
         end
      end else if (we && wb < NB && wa < DEPTH) begin
         m[wb][wa] = d;
      end
      if (clr) begin
         mp = 0; mb = 0;
      end
`ifdef BANKED_MEMORY_OUTREG_EN
      if (pv) exp_data = pd;
      exp_valid = pv;
      pv = re; pd = row;
`else
      if (re) exp_data = row;
      exp_valid = re;
`endif
      #1;
      check_outputs("step");
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0, 0);
   endtask

   task automatic rd(input int ra);
      step(1'b0, 1'b0, 0, 0, 8'h00, 1'b0, 1'b1, ra);
      repeat (LAT - 1) idle();
   endtask

   initial begin
      drive_idle();
      model_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Give every used word a defined value
      for (int a = 0; a < DEPTH; a++)
         for (int b = 0; b < NB; b++)
            step(1'b1, MODE_EXPLICIT, a, b, 8'($urandom), 1'b0, 1'b0, 0);

      // Explicit-address writes and column read
      step(1'b1, MODE_EXPLICIT, 1, 1, 8'hFF, 1'b0, 1'b0, 0);
      step(1'b1, MODE_EXPLICIT, 2, 2, 8'h81, 1'b0, 1'b0, 0);
      rd(1);
      check("mode0.valid", 32'(bus.o_valid), 1);
      check("mode0.bank1", 32'(bus.o_data[15:8]), 32'h FF);
      rd(2);
      check("mode0.bank2", 32'(bus.o_data[23:16]), 32'h81);

      // Stream 12 words across three lines
      for (int i = 0; i < 12; i++) begin
         step(1'b1, MODE_STREAM, 0, 0, 8'(i), 1'b0, 1'b0, 0);
         check("stream.linedone", 32'(bus.o_lineDone), (i % 4 == 3) ? 1 : 0);
         check("stream.bank", 32'(bus.o_wrBank), ((i + 1) / 4) % 3);
      end
      rd(2);
      check("stream.col2", 32'(bus.o_data), 32'h0A0602);

      // Read-first collision on bank 0 addr 0
      step(1'b1, MODE_EXPLICIT, 0, 0, 8'h11, 1'b0, 1'b0, 0);
      step(1'b1, MODE_EXPLICIT, 0, 0, 8'hE7, 1'b0, 1'b1, 0);
      repeat (LAT - 1) idle();
      check("collide.old", 32'(bus.o_data[7:0]), 32'h11);
      rd(0);
      check("collide.new", 32'(bus.o_data[7:0]), 32'hE7);

      // Out-of-range bank and address are ignored
      step(1'b1, MODE_EXPLICIT, 1, 3, 8'hAA, 1'b0, 1'b0, 0);
      step(1'b1, MODE_EXPLICIT, DEPTH, 0, 8'hAA, 1'b0, 1'b0, 0);
      rd(1);
      check("ignore.col1", 32'(bus.o_data), 32'h090501);
      rd(0);
      check("ignore.col0", 32'(bus.o_data), 32'h0804E7);

      // Pointer clear racing a stream write at bank 1 addr 2
      for (int i = 0; i < 6; i++) step(1'b1, MODE_STREAM, 0, 0, 8'(8'h20 + i), 1'b0, 1'b0, 0);
      check("clr.prebank", 32'(bus.o_wrBank), 1);
      step(1'b1, MODE_STREAM, 0, 0, 8'h5C, 1'b1, 1'b0, 0);
      check("clr.bank", 32'(bus.o_wrBank), 0);
      check("clr.linedone", 32'(bus.o_lineDone), 0);
      step(1'b1, MODE_STREAM, 0, 0, 8'h5D, 1'b0, 1'b0, 0);
      rd(2);
      check("clr.landed", 32'(bus.o_data[15:8]), 32'h5C);
      rd(0);
      check("clr.next", 32'(bus.o_data[7:0]), 32'h5D);

      // Randomized mix of modes, clears and reads
      for (int i = 0; i < 300; i++)
         step(1'($urandom), 1'($urandom), int'($urandom % 8), int'($urandom % 4), 8'($urandom),
              ($urandom % 16) == 0, 1'($urandom), int'($urandom % DEPTH));

      // Asynchronous reset mid-stream with a read in flight
      step(1'b1, MODE_STREAM, 0, 0, 8'($urandom), 1'b1, 1'b0, 0);
      for (int i = 0; i < 11; i++) step(1'b1, MODE_STREAM, 0, 0, 8'($urandom), 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 0, 0, 8'h00, 1'b0, 1'b1, 1);
      check("prereset.bank", 32'(bus.o_wrBank), 2);
      #1;
      rst_n = 1'b0;
      drive_idle();
      #1;
      model_reset();
      check("areset.valid", 32'(bus.o_valid), 0);
      check("areset.data", 32'(bus.o_data), 0);
      check("areset.bank", 32'(bus.o_wrBank), 0);
      check("areset.linedone", 32'(bus.o_lineDone), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b0, 0, 0, 8'h00, 1'b0, 1'b1, a);
      repeat (LAT) idle();
      step(1'b1, MODE_STREAM, 0, 0, 8'h77, 1'b0, 1'b0, 0);
      rd(0);
      check("postreset.stream", 32'(bus.o_data[7:0]), 32'h77);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
